sel7seg_mux: RTL and testbench

//  Time-multiplexed driver for NDIG common-anode/cathode 7-segment digits with on-chip hex decode.

---
 rtl/sel7seg_mux.sv | 172 +++++++++++++++++
 tb/tb_sel7seg_mux.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/sel7seg_mux.sv
// Time-multiplexed 7-segment driver: hex decode, decimal points, leading-zero
// blanking, 8-phase PWM brightness with a dark guard phase, per-frame snapshots.
module sel7seg_mux #(
  parameter int NDIG     = 4,
  parameter int PRESCALE = 1024,
  parameter int SEL_ALOW = 1,
  parameter int SEG_ALOW = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [4*NDIG-1:0]     digits,
  input  logic [NDIG-1:0]       dp,
  input  logic                  blank_lz,
  input  logic [2:0]            brightness,
  output logic [6:0]            seg,
  output logic                  dp_out,
  output logic [NDIG-1:0]       sel,
  output logic                  frame_start
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = $clog2(NDIG);
  localparam logic [6:0]      SEG_OFF = (SEG_ALOW != 0) ? 7'h7F : 7'h00;
  localparam logic            DP_OFF  = (SEG_ALOW != 0);
  localparam logic [NDIG-1:0] SEL_OFF = (SEL_ALOW != 0) ? '1 : '0;

  function automatic logic [6:0] hex_glyph(input logic [3:0] v);
    case (v)
      4'h0: hex_glyph = 7'b0111111;
      4'h1: hex_glyph = 7'b0000110;
      4'h2: hex_glyph = 7'b1011011;
      4'h3: hex_glyph = 7'b1001111;
      4'h4: hex_glyph = 7'b1100110;
      4'h5: hex_glyph = 7'b1101101;
      4'h6: hex_glyph = 7'b1111101;
      4'h7: hex_glyph = 7'b0000111;
      4'h8: hex_glyph = 7'b1111111;
      4'h9: hex_glyph = 7'b1101111;
      4'hA: hex_glyph = 7'b1110111;
      4'hB: hex_glyph = 7'b1111100;
      4'hC: hex_glyph = 7'b0111001;
      4'hD: hex_glyph = 7'b1011110;
      4'hE: hex_glyph = 7'b1111001;
      default: hex_glyph = 7'b1110001;
    endcase
  endfunction

  logic [PW-1:0]     presc_q, presc_d;
  logic [2:0]        phase_q, phase_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              pend_q, pend_d;
  logic [4*NDIG-1:0] digits_snap_q, digits_snap_d;
  logic [NDIG-1:0]   dp_snap_q, dp_snap_d;
  logic              lz_snap_q, lz_snap_d;
  logic [2:0]        bright_snap_q, bright_snap_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_out_q, dp_out_d;
  logic [NDIG-1:0]   sel_q, sel_d;
  logic              frame_start_q, frame_start_d;

  logic              tick;
  logic              last_slot;
  logic              zero_above;
  logic [3:0]        cur_nib;
  logic              cur_blanked;
  logic              cur_dp;
  logic              on_phase;
  logic              show;
  logic [6:0]        seg_hi;
  logic [NDIG-1:0]   sel_hi;

  // Scan counters and frame-boundary snapshot capture.
  always_comb begin
    presc_d       = presc_q;
    phase_d       = phase_q;
    idx_d         = idx_q;
    pend_d        = pend_q;
    digits_snap_d = digits_snap_q;
    dp_snap_d     = dp_snap_q;
    lz_snap_d     = lz_snap_q;
    bright_snap_d = bright_snap_q;
    frame_start_d = 1'b0;
    tick          = 1'b0;
    last_slot     = 1'b0;
    if (enable) begin
      tick    = (presc_q == PW'(PRESCALE - 1));
      presc_d = tick ? '0 : presc_q + PW'(1);
      if (tick) begin
        phase_d = phase_q + 3'd1;
        if (phase_q == 3'd7) begin
          if (idx_q == IW'(NDIG - 1)) begin
            idx_d     = '0;
            last_slot = 1'b1;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      frame_start_d = pend_q || last_slot;
      pend_d        = 1'b0;
    end
    if (frame_start_d) begin
      digits_snap_d = digits;
      dp_snap_d     = dp;
      lz_snap_d     = blank_lz;
      bright_snap_d = brightness;
    end
  end

  // Current digit select, blanking and output patterns from the present state.
  always_comb begin
    zero_above  = 1'b1;
    cur_nib     = 4'd0;
    cur_blanked = 1'b0;
    cur_dp      = 1'b0;
    for (int i = NDIG - 1; i >= 0; i--) begin
      zero_above = zero_above && (digits_snap_q[4*i +: 4] == 4'd0);
      if (idx_q == IW'(i)) begin
        cur_nib     = digits_snap_q[4*i +: 4];
        cur_blanked = lz_snap_q && zero_above && (i != 0);
        cur_dp      = dp_snap_q[i];
      end
    end
    on_phase = enable && (phase_q != 3'd7) && (phase_q < bright_snap_q);
    // A blanked digit still lights its select when its decimal point is set.
    show     = on_phase && (!cur_blanked || cur_dp);
    seg_hi   = (show && !cur_blanked) ? hex_glyph(cur_nib) : 7'd0;
    for (int i = 0; i < NDIG; i++) begin
      sel_hi[i] = show && (idx_q == IW'(i));
    end
    seg_d    = (SEG_ALOW != 0) ? ~seg_hi : seg_hi;
    dp_out_d = (SEG_ALOW != 0) ? ~(show && cur_dp) : (show && cur_dp);
    sel_d    = (SEL_ALOW != 0) ? ~sel_hi : sel_hi;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q       <= '0;
      phase_q       <= 3'd0;
      idx_q         <= '0;
      pend_q        <= 1'b1;
      digits_snap_q <= '0;
      dp_snap_q     <= '0;
      lz_snap_q     <= 1'b0;
      bright_snap_q <= 3'd0;
      seg_q         <= SEG_OFF;
      dp_out_q      <= DP_OFF;
      sel_q         <= SEL_OFF;
      frame_start_q <= 1'b0;
    end else begin
      presc_q       <= presc_d;
      phase_q       <= phase_d;
      idx_q         <= idx_d;
      pend_q        <= pend_d;
      digits_snap_q <= digits_snap_d;
      dp_snap_q     <= dp_snap_d;
      lz_snap_q     <= lz_snap_d;
      bright_snap_q <= bright_snap_d;
      seg_q         <= seg_d;
      dp_out_q      <= dp_out_d;
      sel_q         <= sel_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign seg         = seg_q;
  assign dp_out      = dp_out_q;
  assign sel         = sel_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_sel7seg_mux.sv
// Bench for sel7seg_mux: time-indexed reference model plus directed literal pins,
// and a second instance checking the frame period at NDIG=6, PRESCALE=3.
module tb_sel7seg_mux;

  localparam int NDIG     = 4;
  localparam int PRESCALE = 1;
  localparam int FRAME    = 8 * PRESCALE * NDIG;

  logic              clk = 1'b0;
  logic              rst;
  logic              enable;
  logic [4*NDIG-1:0] digits;
  logic [NDIG-1:0]   dp;
  logic              blank_lz;
  logic [2:0]        brightness;
  logic [6:0]        seg;
  logic              dp_out;
  logic [NDIG-1:0]   sel;
  logic              frame_start;

  logic [23:0]       digits2 = 24'h0A5321;
  logic [5:0]        dp2     = 6'b000100;
  logic [6:0]        seg2;
  logic              dp_out2;
  logic [5:0]        sel2;
  logic              frame_start2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sel7seg_mux #(.NDIG(NDIG), .PRESCALE(PRESCALE), .SEL_ALOW(1), .SEG_ALOW(1)) dut (
    .clk(clk), .rst(rst), .enable(enable), .digits(digits), .dp(dp),
    .blank_lz(blank_lz), .brightness(brightness), .seg(seg), .dp_out(dp_out),
    .sel(sel), .frame_start(frame_start)
  );

  sel7seg_mux #(.NDIG(6), .PRESCALE(3), .SEL_ALOW(1), .SEG_ALOW(1)) dut2 (
    .clk(clk), .rst(rst), .enable(1'b1), .digits(digits2), .dp(dp2),
    .blank_lz(1'b1), .brightness(3'd5), .seg(seg2), .dp_out(dp_out2),
    .sel(sel2), .frame_start(frame_start2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: state is just the count of enabled cycles since reset.
  logic [6:0] glyph_tab [0:15] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  int unsigned       t;
  logic [4*NDIG-1:0] m_digits;
  logic [NDIG-1:0]   m_dp;
  logic              m_lz;
  logic [2:0]        m_br;
  logic [NDIG-1:0]   exp_sel;
  logic [6:0]        exp_seg;
  logic              exp_dp;
  logic              exp_fs;
  logic              model_valid = 1'b0;

  always @(posedge clk) begin
    int ph, id;
    logic [3:0] nib;
    logic blanked, dpb, lit;
    logic [NDIG-1:0] one;
    one = 1;
    model_valid = 1'b1;
    if (rst) begin
      t = 0; m_digits = '0; m_dp = '0; m_lz = 1'b0; m_br = 3'd0;
      exp_sel = '1; exp_seg = 7'h7F; exp_dp = 1'b1; exp_fs = 1'b0;
    end else if (!enable) begin
      exp_sel = '1; exp_seg = 7'h7F; exp_dp = 1'b1; exp_fs = 1'b0;
    end else begin
      ph      = (t / PRESCALE) % 8;
      id      = (t / (8 * PRESCALE)) % NDIG;
      nib     = 4'((m_digits >> (4 * id)) & 16'hF);
      blanked = m_lz && (id != 0) && ((m_digits >> (4 * id)) == 0);
      dpb     = m_dp[id];
      lit     = (ph < int'(m_br)) && (ph != 7) && (!blanked || dpb);
      exp_sel = lit ? ~(one << id) : '1;
      exp_seg = (lit && !blanked) ? ~glyph_tab[nib] : 7'h7F;
      exp_dp  = lit ? ~dpb : 1'b1;
      exp_fs  = (t == 0) || ((t % FRAME) == FRAME - 1);
      if (exp_fs) begin
        m_digits = digits; m_dp = dp; m_lz = blank_lz; m_br = brightness;
      end
      t++;
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      check("sel", 32'(sel), 32'(exp_sel));
      check("seg", 32'(seg), 32'(exp_seg));
      check("dp_out", 32'(dp_out), 32'(exp_dp));
      check("frame_start", 32'(frame_start), 32'(exp_fs));
    end
  end

  // Frame period of the second instance: 8*3*6 cycles between frame_start pulses.
  int cyc = 0;
  int last_fs = 0;
  int n_fs = 0;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (rst) begin
      n_fs = 0;
    end else if (frame_start2) begin
      if (n_fs >= 2) check("fs_period2", 32'(cyc - last_fs), 32'd144);
      last_fs = cyc;
      n_fs++;
    end
  end

  initial begin
    rst = 1'b1; enable = 1'b0; digits = 16'h1234; dp = '0; blank_lz = 1'b0; brightness = 3'd7;
    repeat (3) @(negedge clk);
    check("rst_sel", 32'(sel), 32'hF);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_dp", 32'(dp_out), 32'h1);
    check("rst_fs", 32'(frame_start), 32'h0);
    rst = 1'b0; enable = 1'b1;
    @(negedge clk);
    check("first_fs", 32'(frame_start), 32'h1);
    @(negedge clk);
    check("d0_sel", 32'(sel), 32'hE);
    check("d0_seg4", 32'(seg), 32'h19);
    repeat (6) @(negedge clk);
    check("guard_sel", 32'(sel), 32'hF);
    @(negedge clk);
    check("d1_sel", 32'(sel), 32'hD);
    check("d1_seg3", 32'(seg), 32'h30);
    repeat (23) @(negedge clk);
    check("fs_frame2", 32'(frame_start), 32'h1);
    repeat (12) @(negedge clk);
    digits = 16'hABCD;
    repeat (6) @(negedge clk);
    check("old_d2_sel", 32'(sel), 32'hB);
    check("old_d2_seg", 32'(seg), 32'h24);
    repeat (16) @(negedge clk);
    check("new_d0_sel", 32'(sel), 32'hE);
    check("new_d0_segd", 32'(seg), 32'h21);

    brightness = 3'd0; repeat (2 * FRAME) @(negedge clk);
    brightness = 3'd3; repeat (2 * FRAME) @(negedge clk);
    brightness = 3'd6; blank_lz = 1'b1; digits = 16'h0070; repeat (2 * FRAME) @(negedge clk);
    digits = 16'h0000; repeat (2 * FRAME) @(negedge clk);
    dp = 4'b1010; repeat (2 * FRAME) @(negedge clk);
    dp = '0; blank_lz = 1'b0; digits = 16'h1234; brightness = 3'd7;
    repeat (13) @(negedge clk);
    enable = 1'b0; repeat (5) @(negedge clk);
    enable = 1'b1; repeat (2 * FRAME) @(negedge clk);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_sel", 32'(sel), 32'hF);
    check("midrst_seg", 32'(seg), 32'h7F);
    rst = 1'b0;

    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 19) == 0) begin
        for (int n = 0; n < NDIG; n++)
          digits[4*n +: 4] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        dp         = NDIG'($urandom_range(0, 15));
        blank_lz   = 1'($urandom_range(0, 1));
        brightness = 3'($urandom_range(0, 7));
      end
      if ($urandom_range(0, 24) == 0) enable = ~enable;
      else if (!enable && $urandom_range(0, 3) == 0) enable = 1'b1;
      @(negedge clk);
    end
    enable = 1'b1;
    repeat (FRAME) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
